// File: rtl/axi_rd_arbiter_if.sv
// Bus bundle for axi_rd_arbiter: requester-side AR/R channels, the shared AXI4 read
// master port, and status outputs. The master modport is the arbiter's view.
interface axi_rd_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int ID_W    = 4
);
    logic [NUM_REQ-1:0]        s_arvalid;
    logic [NUM_REQ-1:0]        s_arready;
    logic [NUM_REQ*ADDR_W-1:0] s_araddr;
    logic [NUM_REQ*8-1:0]      s_arlen;
    logic [NUM_REQ-1:0]        s_rvalid;
    logic [NUM_REQ-1:0]        s_rready;
    logic [DATA_W-1:0]         s_rdata;
    logic [1:0]                s_rresp;
    logic                      s_rlast;

    logic [ID_W-1:0]           m_arid;
    logic [ADDR_W-1:0]         m_araddr;
    logic [7:0]                m_arlen;
    logic [2:0]                m_arsize;
    logic [1:0]                m_arburst;
    logic                      m_arvalid;
    logic                      m_arready;
    logic [ID_W-1:0]           m_rid;
    logic [DATA_W-1:0]         m_rdata;
    logic [1:0]                m_rresp;
    logic                      m_rlast;
    logic                      m_rvalid;
    logic                      m_rready;

    logic                      err_rid;
    logic                      busy;
    logic [NUM_REQ*16-1:0]     stat_grants;

    modport master (
        input  s_arvalid, s_araddr, s_arlen, s_rready,
        input  m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        output s_arready, s_rvalid, s_rdata, s_rresp, s_rlast,
        output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
        output err_rid, busy, stat_grants
    );

    modport slave (
        output s_arvalid, s_araddr, s_arlen, s_rready,
        output m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        input  s_arready, s_rvalid, s_rdata, s_rresp, s_rlast,
        input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
        input  err_rid, busy, stat_grants
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin AXI4 read arbiter: NUM_REQ clients share one AR/R master port, RID routes beats back.
// Define AXI_RD_ARB_STATS_EN to build the per-requester saturating grant counters.
module axi_rd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int ID_W    = 4,
    parameter int MAX_OUT = 4
) (
    input  logic             aclk,
    input  logic             aresetn,
    axi_rd_arbiter_if.master bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    typedef enum logic {IDLE, ADDR} state_t;

    state_t                        state;
    logic [IDX_W-1:0]              ptr;
    logic [NUM_REQ-1:0][CNT_W-1:0] cnt;
    logic [ID_W-1:0]               ar_id;
    logic [ADDR_W-1:0]             ar_addr;
    logic [7:0]                    ar_len;
    logic                          ar_valid;
    logic                          err_flag;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] route;
    logic [NUM_REQ-1:0] done;
    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic               rid_ok;
    logic [IDX_W-1:0]   rid_idx;
    logic               sel_ready;
    logic               r_last_hs;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    // Scan from ptr upward; descending loop lets the closest eligible index win.
    always_comb begin
        eligible = '0;
        win_vld  = 1'b0;
        win_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++)
            eligible[i] = bus.s_arvalid[i] && (cnt[i] < CNT_MAX);
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (eligible[wrap_add(ptr, k)]) begin
                win_vld = 1'b1;
                win_idx = wrap_add(ptr, k);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (aresetn && state == IDLE && win_vld) grant[win_idx] = 1'b1;
    end

    assign rid_idx = bus.m_rid[IDX_W-1:0];
    assign rid_ok  = ({1'b0, bus.m_rid} < (ID_W+1)'(NUM_REQ));

    // Out-of-range IDs keep sel_ready at 1 so the stray beat drains instead of stalling R.
    always_comb begin
        route     = '0;
        sel_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rid_ok && rid_idx == IDX_W'(i)) begin
                route[i]  = 1'b1;
                sel_ready = bus.s_rready[i];
            end
        end
    end

    assign r_last_hs = bus.m_rvalid && sel_ready && bus.m_rlast;
    assign done      = r_last_hs ? route : '0;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            ptr      <= '0;
            ar_valid <= 1'b0;
            ar_id    <= '0;
            ar_addr  <= '0;
            ar_len   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        ar_valid <= 1'b1;
                        ar_id    <= ID_W'(win_idx);
                        ar_addr  <= bus.s_araddr[win_idx*ADDR_W +: ADDR_W];
                        ar_len   <= bus.s_arlen[win_idx*8 +: 8];
                        ptr      <= wrap_add(win_idx, 1);
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.m_arready) begin
                        ar_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A grant and a completion on the same requester cancel out.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt      <= '0;
            err_flag <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && !done[i])
                    cnt[i] <= cnt[i] + CNT_W'(1);
                else if (done[i] && !grant[i] && cnt[i] != '0)
                    cnt[i] <= cnt[i] - CNT_W'(1);
            end
            if (bus.m_rvalid && !rid_ok) err_flag <= 1'b1;
        end
    end

    assign bus.s_arready = grant;
    assign bus.m_arvalid = ar_valid;
    assign bus.m_arid    = ar_id;
    assign bus.m_araddr  = ar_addr;
    assign bus.m_arlen   = ar_len;
    assign bus.m_arsize  = 3'($clog2(DATA_W / 8));
    assign bus.m_arburst = 2'b01;

    assign bus.s_rvalid = bus.m_rvalid ? route : '0;
    assign bus.s_rdata  = bus.m_rdata;
    assign bus.s_rresp  = bus.m_rresp;
    assign bus.s_rlast  = bus.m_rlast;
    assign bus.m_rready = sel_ready;

    assign bus.err_rid = err_flag;
    assign bus.busy    = ar_valid || (|cnt);

`ifdef AXI_RD_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] stat;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (grant[i]) stat[i] <= sat_inc16(stat[i]);
        end
    end

    assign bus.stat_grants = stat;
`else
    assign bus.stat_grants = '0;
`endif
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: reset values, RR order, outstanding limits, RID routing/errors.
// Stat-counter expectations follow AXI_RD_ARB_STATS_EN.
module tb_axi_rd_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int ID_W    = 4;
    localparam int MAX_OUT = 4;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;

    always #5 aclk = ~aclk;

    axi_rd_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    axi_rd_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_OUT(MAX_OUT)
    ) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic smp();
        @(negedge aclk);
    endtask

    task automatic do_reset();
        tick();
        aresetn        = 1'b0;
        bus.s_arvalid  = '0;
        bus.s_rready   = '0;
        bus.m_rvalid   = 1'b0;
        bus.m_rlast    = 1'b0;
        tick();
        aresetn = 1'b1;
    endtask

    initial begin
        bus.s_arvalid = '0;
        bus.s_araddr  = '0;
        bus.s_arlen   = '0;
        bus.s_rready  = '0;
        bus.m_arready = 1'b0;
        bus.m_rid     = '0;
        bus.m_rdata   = '0;
        bus.m_rresp   = '0;
        bus.m_rlast   = 1'b0;
        bus.m_rvalid  = 1'b0;

        // Reset values, with requester 1 already presenting a request
        bus.s_arvalid            = 4'b0010;
        bus.s_araddr[1*32 +: 32] = 32'h0000_1000;
        bus.s_arlen[1*8 +: 8]    = 8'd7;
        bus.m_arready            = 1'b1;
        smp();
        check("rst_arvalid", bus.m_arvalid, 0);
        check("rst_arready", bus.s_arready, 0);
        check("rst_arid", bus.m_arid, 0);
        check("rst_araddr", bus.m_araddr, 0);
        check("rst_arlen", bus.m_arlen, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err_rid, 0);
        check("rst_stat", bus.stat_grants, 0);
        check("arsize", bus.m_arsize, 3);
        check("arburst", bus.m_arburst, 1);

        // Single requester 1
        tick();
        aresetn = 1'b1;
        smp();
        check("t1_grant", bus.s_arready, 4'b0010);
        tick();
        bus.s_arvalid = '0;
        smp();
        check("t1_arvalid", bus.m_arvalid, 1);
        check("t1_arid", bus.m_arid, 1);
        check("t1_araddr", bus.m_araddr, 32'h1000);
        check("t1_arlen", bus.m_arlen, 7);
        check("t1_noready_addr", bus.s_arready, 0);
        check("t1_busy_addr", bus.busy, 1);
        tick();
        smp();
        check("t1_arvalid_drop", bus.m_arvalid, 0);
        check("t1_busy_out", bus.busy, 1);
        tick();
        bus.m_rvalid = 1'b1;
        bus.m_rid    = 4'd1;
        bus.m_rresp  = 2'b10;
        smp();
        check("t1_stall_rvalid", bus.s_rvalid, 4'b0010);
        check("t1_stall_rready", bus.m_rready, 0);
        check("t1_rresp", bus.s_rresp, 2'b10);
        bus.m_rresp = 2'b00;
        for (int b = 0; b < 8; b++) begin
            tick();
            bus.s_rready = 4'b0010;
            bus.m_rdata  = 64'hA5A5_0000_0000_00A0 + 64'(b);
            bus.m_rlast  = (b == 7);
            smp();
            check("t1_rvalid", bus.s_rvalid, 4'b0010);
            check("t1_rready", bus.m_rready, 1);
            if (b == 0) check("t1_rdata0", bus.s_rdata, 64'hA5A5_0000_0000_00A0);
            if (b == 7) begin
                check("t1_rlast", bus.s_rlast, 1);
                check("t1_busy_last", bus.busy, 1);
            end
        end
        tick();
        bus.m_rvalid = 1'b0;
        bus.m_rlast  = 1'b0;
        bus.s_rready = '0;
        smp();
        check("t1_busy_done", bus.busy, 0);
        check("t1_rvalid_idle", bus.s_rvalid, 0);

        // All four requesting: order 0,1,2,3,0,... one grant per 2 cycles
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.s_araddr[i*32 +: 32] = 32'h100 * (i + 1);
            bus.s_arlen[i*8 +: 8]    = 8'(i);
        end
        bus.s_arvalid = 4'b1111;
        bus.m_arready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            smp();
            check("t2_grant", bus.s_arready, 64'(1) << (k % 4));
            tick();
            smp();
            check("t2_arvalid", bus.m_arvalid, 1);
            check("t2_arid", bus.m_arid, k % 4);
            check("t2_araddr", bus.m_araddr, 32'h100 * (k % 4 + 1));
            check("t2_gap", bus.s_arready, 0);
            tick();
        end
        bus.s_arvalid = '0;

        // Outstanding limit on requester 2
        do_reset();
        bus.s_arvalid = 4'b0100;
        for (int g = 0; g < 4; g++) begin
            smp();
            check("t3_grant", bus.s_arready, 4'b0100);
            tick();
            smp();
            tick();
        end
        smp();
        check("t3_block", bus.s_arready, 0);
        tick();
        smp();
        check("t3_block2", bus.s_arready, 0);
        check("t3_no_arvalid", bus.m_arvalid, 0);
        tick();
        bus.m_rvalid = 1'b1;
        bus.m_rid    = 4'd2;
        bus.m_rlast  = 1'b1;
        bus.s_rready = 4'b0100;
        smp();
        check("t3_block_on_last", bus.s_arready, 0);
        check("t3_rvalid", bus.s_rvalid, 4'b0100);
        tick();
        bus.m_rvalid = 1'b0;
        bus.m_rlast  = 1'b0;
        bus.s_rready = '0;
        smp();
        check("t3_fifth", bus.s_arready, 4'b0100);
        tick();
        bus.s_arvalid = '0;
        smp();
        check("t3_fifth_id", bus.m_arid, 2);

        // Grant and last beat on requester 0 in the same cycle with cnt[0]=2
        do_reset();
        bus.s_arvalid = 4'b0001;
        for (int g = 0; g < 2; g++) begin
            smp();
            check("t4_pre_grant", bus.s_arready, 4'b0001);
            tick();
            smp();
            tick();
        end
        bus.m_rvalid = 1'b1;
        bus.m_rid    = 4'd0;
        bus.m_rlast  = 1'b1;
        bus.s_rready = 4'b0001;
        smp();
        check("t4_both_grant", bus.s_arready, 4'b0001);
        check("t4_both_rvalid", bus.s_rvalid, 4'b0001);
        tick();
        bus.m_rvalid = 1'b0;
        bus.m_rlast  = 1'b0;
        bus.s_rready = '0;
        smp();
        tick();
        smp();
        check("t4_grant_cnt2", bus.s_arready, 4'b0001);
        tick();
        smp();
        tick();
        smp();
        check("t4_grant_cnt3", bus.s_arready, 4'b0001);
        tick();
        smp();
        tick();
        smp();
        check("t4_block_cnt4", bus.s_arready, 0);
        bus.s_arvalid = '0;

        // Out-of-range RIDs
        do_reset();
        bus.m_rvalid = 1'b1;
        bus.m_rid    = 4'd6;
        bus.s_rready = '0;
        smp();
        check("t5_rready6", bus.m_rready, 1);
        check("t5_rvalid6", bus.s_rvalid, 0);
        check("t5_err_pre", bus.err_rid, 0);
        tick();
        bus.m_rid = 4'd4;
        smp();
        check("t5_err_set", bus.err_rid, 1);
        check("t5_rvalid4", bus.s_rvalid, 0);
        check("t5_rready4", bus.m_rready, 1);
        tick();
        bus.m_rvalid = 1'b0;
        tick();
        tick();
        smp();
        check("t5_err_sticky", bus.err_rid, 1);
        check("t5_busy", bus.busy, 0);
        do_reset();
        smp();
        check("t5_err_clr", bus.err_rid, 0);

        // Async reset while in ADDR with cnt[3]=3
        tick();
        bus.s_araddr[3*32 +: 32] = 32'hBEEF_0000;
        bus.s_arvalid            = 4'b1000;
        bus.m_arready            = 1'b1;
        for (int g = 0; g < 2; g++) begin
            smp();
            check("t6_grant", bus.s_arready, 4'b1000);
            tick();
            smp();
            tick();
        end
        smp();
        check("t6_grant3", bus.s_arready, 4'b1000);
        tick();
        bus.m_arready = 1'b0;
        smp();
        check("t6_arvalid", bus.m_arvalid, 1);
`ifdef AXI_RD_ARB_STATS_EN
        check("t6_stat3", bus.stat_grants, 64'h0003_0000_0000_0000);
`else
        check("t6_stat_off", bus.stat_grants, 0);
`endif
        tick();
        smp();
        check("t6_hold", bus.m_arvalid, 1);
        check("t6_hold_addr", bus.m_araddr, 32'hBEEF_0000);
        #2;
        aresetn = 1'b0;
        #1;
        check("t6_rst_arvalid", bus.m_arvalid, 0);
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_araddr", bus.m_araddr, 0);
        check("t6_rst_arready", bus.s_arready, 0);
        check("t6_rst_stat", bus.stat_grants, 0);
        tick();
        aresetn       = 1'b1;
        bus.s_arvalid = '0;
        smp();
        check("t6_post_busy", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
